// File: rtl/vga_timing_detect.sv
// Receive-side VGA mode detector: measures hsync/vsync periods, sync widths and
// polarities against the pixel clock and raises locked once the mode is stable.
module vga_timing_detect #(
  parameter int CNT_W       = 12,
  parameter int LOCK_FRAMES = 2
) (
  input  logic             clk_pixel,
  input  logic             reset,
  input  logic             hsync_in,
  input  logic             vsync_in,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] h_sync_width,
  output logic             hsync_pol,
  output logic [CNT_W-1:0] v_total,
  output logic [CNT_W-1:0] v_sync_width,
  output logic             vsync_pol,
  output logic             locked,
  output logic             frame_strobe
);

  localparam int MW = (LOCK_FRAMES > 1) ? $clog2(LOCK_FRAMES) : 1;
  localparam int LOCK_TGT_I = LOCK_FRAMES - 1;
  localparam logic [MW:0] LOCK_TGT = LOCK_TGT_I[MW:0];
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_SEARCH,
    S_CONFIRM,
    S_LOCKED
  } state_t;

  // Bit 0 carries hsync, bit 1 carries vsync through identical front ends.
  logic [1:0] w_raw;
  logic [1:0] r_s1;
  logic [1:0] r_s2;
  logic [1:0] r_d;
  logic [1:0] r_arm;
  logic [1:0] r_rise;
  logic [1:0] r_fill;

  assign w_raw = {vsync_in, hsync_in};

  // An edge is only reported once the synchronized input has really been low
  // after reset, so a sync already active at reset release is not a rise.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_d    <= '0;
      r_arm  <= '0;
      r_rise <= '0;
      r_fill <= '0;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
      r_d  <= r_s2;
      if (r_fill != 2'd2) r_fill <= r_fill + 2'd1;
      for (int i = 0; i < 2; i++) begin
        if (r_fill == 2'd2 && !r_s2[i]) r_arm[i] <= 1'b1;
        r_rise[i] <= r_s2[i] & ~r_d[i] & r_arm[i];
      end
    end
  end

  logic w_hs_rise;
  logic w_vs_rise;
  logic w_hs_sync;
  logic w_vs_sync;

  assign w_hs_rise = r_rise[0];
  assign w_vs_rise = r_rise[1];
  assign w_hs_sync = r_d[0];
  assign w_vs_sync = r_d[1];

  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_h_hi;
  logic             r_h_started;
  logic [CNT_W-1:0] r_h_total;
  logic [CNT_W-1:0] r_h_sync_width;
  logic             r_hsync_pol;

  logic [CNT_W-1:0] r_v_cnt;
  logic [CNT_W-1:0] r_v_hi;
  logic             r_v_started;
  logic [CNT_W-1:0] r_v_total;
  logic [CNT_W-1:0] r_v_sync_width;
  logic             r_vsync_pol;
  logic             r_frame_strobe;

  logic w_h_sat;
  logic w_v_sat;
  logic w_timeout;

  assign w_h_sat = (r_h_cnt == CNT_MAX);
  assign w_v_sat = (r_v_cnt == CNT_MAX);
  // A rise arriving while saturated ends the stall, so it is not a timeout.
  assign w_timeout = (w_h_sat & ~w_hs_rise) | w_v_sat;

  logic [CNT_W:0]   w_h_period;
  logic [CNT_W:0]   w_h_high;
  logic             w_h_pol;
  logic [CNT_W-1:0] w_h_width;

  assign w_h_period = {1'b0, r_h_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign w_h_high   = {1'b0, r_h_hi};
  assign w_h_pol    = ({r_h_hi, 1'b0} < w_h_period);
  assign w_h_width  = w_h_pol ? r_h_hi : CNT_W'(w_h_period - w_h_high);

  logic [CNT_W:0]   w_v_len;
  logic [CNT_W:0]   w_v_high;
  logic             w_v_pol;
  logic [CNT_W-1:0] w_v_width;
  logic             w_v_capture;

  assign w_v_len     = {1'b0, r_v_cnt};
  assign w_v_high    = {1'b0, r_v_hi};
  assign w_v_pol     = ({r_v_hi, 1'b0} < w_v_len);
  assign w_v_width   = w_v_pol ? r_v_hi : CNT_W'(w_v_len - w_v_high);
  assign w_v_capture = w_vs_rise & r_v_started & ~w_timeout;

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_h_cnt        <= '0;
      r_h_hi         <= '0;
      r_h_started    <= 1'b0;
      r_h_total      <= '0;
      r_h_sync_width <= '0;
      r_hsync_pol    <= 1'b0;
    end else begin
      if (w_hs_rise) begin
        if (r_h_started && !w_h_sat) begin
          r_h_total      <= w_h_period[CNT_W-1:0];
          r_h_sync_width <= w_h_width;
          r_hsync_pol    <= w_h_pol;
        end
        r_h_cnt     <= '0;
        r_h_hi      <= CNT_ONE;
        r_h_started <= 1'b1;
      end else begin
        if (!w_h_sat) r_h_cnt <= r_h_cnt + CNT_ONE;
        if (w_hs_sync && r_h_hi != CNT_MAX) r_h_hi <= r_h_hi + CNT_ONE;
      end
      if (w_timeout) begin
        r_h_started    <= 1'b0;
        r_h_total      <= '0;
        r_h_sync_width <= '0;
        r_hsync_pol    <= 1'b0;
      end
    end
  end

  // A coincident hsync edge belongs to the new frame, not the one being closed.
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_v_cnt        <= '0;
      r_v_hi         <= '0;
      r_v_started    <= 1'b0;
      r_v_total      <= '0;
      r_v_sync_width <= '0;
      r_vsync_pol    <= 1'b0;
      r_frame_strobe <= 1'b0;
    end else begin
      r_frame_strobe <= 1'b0;
      if (w_vs_rise) begin
        if (w_v_capture) begin
          r_v_total      <= r_v_cnt;
          r_v_sync_width <= w_v_width;
          r_vsync_pol    <= w_v_pol;
          r_frame_strobe <= 1'b1;
        end
        r_v_started <= 1'b1;
        if (w_hs_rise) begin
          r_v_cnt <= CNT_ONE;
          r_v_hi  <= w_vs_sync ? CNT_ONE : '0;
        end else begin
          r_v_cnt <= '0;
          r_v_hi  <= '0;
        end
      end else if (w_hs_rise) begin
        if (!w_v_sat) r_v_cnt <= r_v_cnt + CNT_ONE;
        if (w_vs_sync && r_v_hi != CNT_MAX) r_v_hi <= r_v_hi + CNT_ONE;
      end
      if (w_timeout) begin
        r_v_started    <= 1'b0;
        r_v_cnt        <= '0;
        r_v_hi         <= '0;
        r_v_total      <= '0;
        r_v_sync_width <= '0;
        r_vsync_pol    <= 1'b0;
        r_frame_strobe <= 1'b0;
      end
    end
  end

  state_t           r_state;
  logic [MW-1:0]    r_match_cnt;
  logic             r_have_prev;
  logic             r_locked;
  logic [CNT_W-1:0] r_prev_h_total;
  logic [CNT_W-1:0] r_prev_v_total;
  logic             r_prev_hpol;
  logic             r_prev_vpol;
  logic             w_match;
  logic [MW:0]      w_cnt_inc;

  assign w_match = r_have_prev
                 && (r_prev_h_total == r_h_total)
                 && (r_prev_v_total == r_v_cnt)
                 && (r_prev_hpol == r_hsync_pol)
                 && (r_prev_vpol == w_v_pol);
  assign w_cnt_inc = {1'b0, r_match_cnt} + {{MW{1'b0}}, 1'b1};

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_state        <= S_SEARCH;
      r_match_cnt    <= '0;
      r_have_prev    <= 1'b0;
      r_locked       <= 1'b0;
      r_prev_h_total <= '0;
      r_prev_v_total <= '0;
      r_prev_hpol    <= 1'b0;
      r_prev_vpol    <= 1'b0;
    end else if (w_timeout) begin
      r_state     <= S_SEARCH;
      r_match_cnt <= '0;
      r_have_prev <= 1'b0;
      r_locked    <= 1'b0;
    end else if (w_v_capture) begin
      r_prev_h_total <= r_h_total;
      r_prev_v_total <= r_v_cnt;
      r_prev_hpol    <= r_hsync_pol;
      r_prev_vpol    <= w_v_pol;
      r_have_prev    <= 1'b1;
      if (!r_have_prev) begin
        r_state     <= S_CONFIRM;
        r_match_cnt <= '0;
        r_locked    <= 1'b0;
      end else if (w_match) begin
        if (r_state == S_LOCKED || w_cnt_inc >= LOCK_TGT) begin
          r_state     <= S_LOCKED;
          r_locked    <= 1'b1;
          r_match_cnt <= LOCK_TGT[MW-1:0];
        end else begin
          r_state     <= S_CONFIRM;
          r_locked    <= 1'b0;
          r_match_cnt <= w_cnt_inc[MW-1:0];
        end
      end else begin
        r_state     <= S_SEARCH;
        r_match_cnt <= '0;
        r_locked    <= 1'b0;
      end
    end
  end

  assign h_total      = r_h_total;
  assign h_sync_width = r_h_sync_width;
  assign hsync_pol    = r_hsync_pol;
  assign v_total      = r_v_total;
  assign v_sync_width = r_v_sync_width;
  assign vsync_pol    = r_vsync_pol;
  assign locked       = r_locked;
  assign frame_strobe = r_frame_strobe;

endmodule

// File: tb/tb_vga_timing_detect.sv
// Directed bench for vga_timing_detect: full-width horizontal modelines, short-line
// frames carrying the 628/525-line vertical timings, mode switch, timeout, reset.
module tb_vga_timing_detect;

  localparam int CNT_W = 12;

  logic             clk_pixel = 1'b0;
  logic             reset;
  logic             hsync_in;
  logic             vsync_in;
  logic [CNT_W-1:0] h_total;
  logic [CNT_W-1:0] h_sync_width;
  logic             hsync_pol;
  logic [CNT_W-1:0] v_total;
  logic [CNT_W-1:0] v_sync_width;
  logic             vsync_pol;
  logic             locked;
  logic             frame_strobe;

  vga_timing_detect #(.CNT_W(CNT_W), .LOCK_FRAMES(2)) dut (
    .clk_pixel   (clk_pixel),
    .reset       (reset),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .h_total     (h_total),
    .h_sync_width(h_sync_width),
    .hsync_pol   (hsync_pol),
    .v_total     (v_total),
    .v_sync_width(v_sync_width),
    .vsync_pol   (vsync_pol),
    .locked      (locked),
    .frame_strobe(frame_strobe)
  );

  always #5 clk_pixel = ~clk_pixel;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // Strobe counter plus the strobe index at which locked last rose/fell.
  int   strobe_cnt   = 0;
  int   lock_rise_at = -1;
  int   drop_at      = -1;
  logic locked_q     = 1'b0;

  always @(negedge clk_pixel) begin
    if (frame_strobe) strobe_cnt <= strobe_cnt + 1;
    if (locked && !locked_q) lock_rise_at <= strobe_cnt + (frame_strobe ? 1 : 0);
    if (!locked && locked_q) drop_at <= strobe_cnt + (frame_strobe ? 1 : 0);
    locked_q <= locked;
  end

  task automatic tick();
    @(posedge clk_pixel);
    #1;
  endtask

  task automatic drive_line(input int h_tot, input int h_sync, input bit h_pos, input bit vs_lvl);
    for (int c = 0; c < h_tot; c++) begin
      hsync_in = (c < h_sync) ? h_pos : !h_pos;
      vsync_in = vs_lvl;
      tick();
    end
  endtask

  // Mode A: 8-clock lines (sync 2, positive), 628 lines (sync 4, positive).
  task automatic lines_a(input int first, input int last);
    for (int l = first; l <= last; l++) drive_line(8, 2, 1'b1, (l < 4) ? 1'b1 : 1'b0);
  endtask

  // Mode B: 10-clock lines (sync 2, negative), 525 lines (sync 2, negative).
  task automatic lines_b(input int first, input int last);
    for (int l = first; l <= last; l++) drive_line(10, 2, 1'b0, (l < 2) ? 1'b0 : 1'b1);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    repeat (10) tick();
  endtask

  task automatic check_meas(input string tag, input int ht, input int hw, input int hp,
                            input int vt, input int vw, input int vp);
    check({tag, "_h_total"}, h_total, ht);
    check({tag, "_h_sync_width"}, h_sync_width, hw);
    check({tag, "_hsync_pol"}, hsync_pol, hp);
    check({tag, "_v_total"}, v_total, vt);
    check({tag, "_v_sync_width"}, v_sync_width, vw);
    check({tag, "_vsync_pol"}, vsync_pol, vp);
  endtask

  int base;

  initial begin
    reset    = 1'b1;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    repeat (3) tick();
    check_meas("reset", 0, 0, 0, 0, 0, 0);
    check("reset_locked", locked, 0);
    check("reset_strobe", frame_strobe, 0);
    reset = 1'b0;
    repeat (10) tick();

    // 800x600 horizontal: 1056 total, 128 sync, positive.
    repeat (3) drive_line(1056, 128, 1'b1, 1'b0);
    check("h800_total", h_total, 1056);
    check("h800_width", h_sync_width, 128);
    check("h800_pol", hsync_pol, 1);
    check("h800_no_vert", v_total, 0);
    check("h800_no_strobe", strobe_cnt, 0);

    // 640x480 horizontal: 800 total, 96 sync, negative.
    repeat (3) drive_line(800, 96, 1'b0, 1'b0);
    check("h640_total", h_total, 800);
    check("h640_width", h_sync_width, 96);
    check("h640_pol", hsync_pol, 0);

    // Mode A from reset; every vsync edge coincides with an hsync edge.
    do_reset();
    base = strobe_cnt;
    repeat (3) lines_a(0, 627);
    lines_a(0, 0);
    check_meas("modeA", 8, 2, 1, 628, 4, 1);
    check("modeA_locked", locked, 1);
    check("modeA_strobes", strobe_cnt - base, 3);
    check("modeA_lock_at_strobe", lock_rise_at - base, 2);

    // Switch to mode B in the middle of a frame.
    base = strobe_cnt;
    lines_a(1, 299);
    repeat (2) lines_b(0, 524);
    lines_b(0, 2);
    check("switch_drop_at_strobe", drop_at - base, 1);
    check("switch_relock_at_strobe", lock_rise_at - base, 3);
    check_meas("modeB", 10, 2, 0, 525, 2, 0);
    check("modeB_locked", locked, 1);

    // Both syncs stall long enough for the line counter to saturate.
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    repeat (4200) tick();
    check("timeout_locked", locked, 0);
    check_meas("timeout", 0, 0, 0, 0, 0, 0);
    base = strobe_cnt;
    repeat (3) lines_a(0, 627);
    lines_a(0, 0);
    check("resume_lock_at_strobe", lock_rise_at - base, 2);
    check("resume_locked", locked, 1);
    check_meas("resume", 8, 2, 1, 628, 4, 1);

    // Reset mid-frame while locked.
    lines_a(1, 99);
    reset    = 1'b1;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    tick();
    reset = 1'b0;
    check_meas("midreset", 0, 0, 0, 0, 0, 0);
    check("midreset_locked", locked, 0);
    check("midreset_strobe", frame_strobe, 0);
    base = strobe_cnt;
    lines_a(100, 627);
    lines_a(0, 0);
    check("midreset_first_vs_no_strobe", strobe_cnt - base, 0);
    lines_a(1, 627);
    lines_a(0, 0);
    check("midreset_second_vs_strobe", strobe_cnt - base, 1);
    check("midreset_v_total", v_total, 628);
    check("midreset_not_yet_locked", locked, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_detect.md
# vga_timing_detect

Measures an incoming VGA-style hsync/vsync pair clocked against the local pixel clock and reports the horizontal and vertical totals, sync widths and sync polarities. It asserts a lock flag once the mode is stable. It sits at the input of a capture or scaler path, or on a loopback test fixture, as the receive-side counterpart of the sync generator. Its outputs read back the same modeline numbers the generator is parameterised with.

## Interface
- CNT_W, 12: width of all counters and measurement outputs.
- LOCK_FRAMES, 2: consecutive identical frame measurements required to assert locked.
- clk_pixel  in  1  pixel clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; one clock, reset synchronous and active-high.
- hsync_in  in  1  raw horizontal sync, asynchronous, either polarity.
- vsync_in  in  1  raw vertical sync, asynchronous, either polarity.
- h_total  out  CNT_W  clocks between successive hsync rising edges.
- h_sync_width  out  CNT_W  clocks in the active sync phase of hsync.
- hsync_pol  out  1  1 = active-high sync.
- v_total  out  CNT_W  lines (hsync rising edges) between successive vsync rising edges.
- v_sync_width  out  CNT_W  lines in the active sync phase of vsync.
- vsync_pol  out  1  1 = active-high sync.
- locked  out  1  measurement stable for LOCK_FRAMES frames.
- frame_strobe  out  1  one-cycle pulse when a vertical measurement is captured.

## Operation
- Each sync input passes through a 2-flop synchronizer, then a 1-flop edge detector. `hs_rise` and `vs_rise` are 1-cycle pulses.
- Horizontal path, on the synced hsync:
  - `h_cnt` increments every clock.
  - `h_hi` increments every clock while synced hsync = 1.
  - On `hs_rise`: capture period P = `h_cnt` + 1 and high time H = `h_hi`, then reset `h_cnt` to 0 and `h_hi` to 1.
- Horizontal polarity and width:
  - hsync_pol = (2·H < P).
  - h_sync_width = H if hsync_pol, else P − H.
  - h_total = P.
  - Arithmetic is done in CNT_W+1 bits. Outputs are truncated to CNT_W.
- Vertical path:
  - `v_cnt` increments on each `hs_rise`.
  - `v_hi` increments on each `hs_rise` while synced vsync = 1.
  - On `vs_rise`: capture L = `v_cnt` and VH = `v_hi`, then clear both.
  - vsync_pol, v_sync_width and v_total are derived as in the horizontal path.
  - frame_strobe pulses the cycle after capture.
- Simultaneous `hs_rise` and `vs_rise`: the frame is captured without counting that hsync edge. The counter then restarts at `v_cnt` = 1, and at `v_hi` = 1 if vsync is high.
- Lock state machine:
  - States: SEARCH, CONFIRM, LOCKED.
  - Each `vs_rise` compares the new (h_total, v_total, hsync_pol, vsync_pol) with the previous capture.
    - Match: a match counter increments. Reaching LOCK_FRAMES−1 enters LOCKED.
    - Mismatch in any state: return to SEARCH with the match counter at 0.
  - The very first `vs_rise` after reset only stores the capture (SEARCH → CONFIRM).
  - locked = 1 only in LOCKED.
- Timeout:
  - If `h_cnt` reaches all-ones, it saturates (no wrap).
  - Saturation, or `v_cnt` saturating, forces SEARCH and locked = 0. It also zeroes all measurement outputs until the next valid capture.
- Reset:
  - All counters, measurement outputs, hsync_pol, vsync_pol, locked and frame_strobe go to 0.
  - State goes to SEARCH.
  - Synchronizer flops go to 0.
  - Reset applied mid-frame discards partial counts. A rising edge is not reported until the synced input has been seen low after reset.

## Timing
- Latency from a hsync_in rising edge (first sampled high) to `hs_rise`: 3 clocks. h_* outputs update 1 clock later (4 total).
- v_* outputs update 4 clocks after the vsync_in rising edge sample. frame_strobe pulses in the same cycle the v_* outputs update.
- locked changes in the same cycle as frame_strobe.
- The first h_total is valid after the second hsync rising edge following reset.
- Throughput: one h measurement per line and one v measurement per frame. No back-pressure.

## Test plan
- 800x600 positive sync (H 1056 / sync 128, V 628 / sync 4) -> h_total 1056, h_sync_width 128, v_total 628, v_sync_width 4, both pols 1. locked rises on the 3rd `vs_rise`.
- 640x480 negative sync (H 800 / sync 96, V 525 / sync 2) -> 800 / 96 / 525 / 2, hsync_pol 0, vsync_pol 0, locked after 3 frames.
- Locked on 800x600, then switch to 640x480 mid-frame -> locked drops at the next `vs_rise`, re-asserts 2 frames later with the new values.
- hsync_in held constant for 4096 clocks -> h_cnt saturates, locked = 0, all measurements read 0. Resume 800x600 -> relock after 3 frames.
- Reset pulsed mid-frame while locked -> all outputs 0 the next cycle. A measurement resumes with no spurious frame_strobe before the second `vs_rise`.
- hsync and vsync rising edges coincident on the same clock -> v_total still 628, not 627 or 629.
